// File: rtl/load_buffer.sv
// In-order load queue: issues one memory read at a time from the head entry,
// then sign/zero-extends the returned data and broadcasts it on the CDB.
module load_buffer #(
  parameter int unsigned DEPTH         = 8,
  parameter int unsigned PTR_W         = 3,
  parameter int unsigned IDWidth       = 32,
  parameter int unsigned ROBWidth      = 5,
  parameter int unsigned AddressWidth  = 32,
  parameter int unsigned InstTypeWidth = 6,
  parameter logic [InstTypeWidth-1:0] LB  = 6'd11,
  parameter logic [InstTypeWidth-1:0] LH  = 6'd12,
  parameter logic [InstTypeWidth-1:0] LW  = 6'd13,
  parameter logic [InstTypeWidth-1:0] LBU = 6'd14,
  parameter logic [InstTypeWidth-1:0] LHU = 6'd15
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic                     rdy_in,
  output logic                     lbuffer_rs_rdy_out,
  input  logic                     addrunit_lbuffer_en_in,
  input  logic [AddressWidth-1:0]  addrunit_lbuffer_addr_in,
  input  logic [ROBWidth-1:0]      addrunit_lbuffer_dest_in,
  input  logic [InstTypeWidth-1:0] addrunit_lbuffer_opcode_in,
  output logic                     lbuffer_mem_en_out,
  output logic [AddressWidth-1:0]  lbuffer_mem_addr_out,
  output logic [1:0]               lbuffer_mem_size_out,
  input  logic                     mem_lbuffer_valid_in,
  input  logic [IDWidth-1:0]       mem_lbuffer_data_in,
  input  logic                     rob_lbuffer_rst_in,
  output logic [ROBWidth-1:0]      cdb_lbuffer_b_out,
  output logic [IDWidth-1:0]       cdb_lbuffer_result_out
);

  typedef enum logic [1:0] {IDLE, WAIT, DRAIN} state_e;

  state_e                   state_q;
  logic [AddressWidth-1:0]  addr_mem_q [DEPTH];
  logic [ROBWidth-1:0]      dest_mem_q [DEPTH];
  logic [InstTypeWidth-1:0] op_mem_q   [DEPTH];
  logic [PTR_W-1:0]         head_q, tail_q;
  logic [PTR_W:0]           count_q, count_d;
  logic                     mem_en_q;
  logic [AddressWidth-1:0]  mem_addr_q;
  logic [1:0]               mem_size_q;
  logic [ROBWidth-1:0]      cdb_b_q;
  logic [IDWidth-1:0]       cdb_result_q;

  logic                     full, push, pop;
  logic [InstTypeWidth-1:0] head_op;
  logic [1:0]               head_size;
  logic [IDWidth-1:0]       ext_data;

  assign full    = (count_q == (PTR_W+1)'(DEPTH));
  assign push    = addrunit_lbuffer_en_in && !full;
  assign pop     = (state_q == WAIT) && mem_lbuffer_valid_in;
  assign head_op = op_mem_q[head_q];

  // One slot of slack absorbs a load already in flight through the address unit.
  assign lbuffer_rs_rdy_out     = (count_q <= (PTR_W+1)'(DEPTH - 2));
  assign lbuffer_mem_en_out     = mem_en_q;
  assign lbuffer_mem_addr_out   = mem_addr_q;
  assign lbuffer_mem_size_out   = mem_size_q;
  assign cdb_lbuffer_b_out      = cdb_b_q;
  assign cdb_lbuffer_result_out = cdb_result_q;

  always_comb begin
    count_d = count_q;
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (pop && !push) count_d = count_q - 1'b1;
  end

  always_comb begin
    ext_data  = mem_lbuffer_data_in;
    head_size = 2'd2;
    case (head_op)
      LB: begin
        ext_data  = {{(IDWidth-8){mem_lbuffer_data_in[7]}}, mem_lbuffer_data_in[7:0]};
        head_size = 2'd0;
      end
      LBU: begin
        ext_data  = {{(IDWidth-8){1'b0}}, mem_lbuffer_data_in[7:0]};
        head_size = 2'd0;
      end
      LH: begin
        ext_data  = {{(IDWidth-16){mem_lbuffer_data_in[15]}}, mem_lbuffer_data_in[15:0]};
        head_size = 2'd1;
      end
      LHU: begin
        ext_data  = {{(IDWidth-16){1'b0}}, mem_lbuffer_data_in[15:0]};
        head_size = 2'd1;
      end
      default: begin
        ext_data  = mem_lbuffer_data_in;
        head_size = 2'd2;
      end
    endcase
  end

  // Entry storage needs no reset: count gates every read.
  always_ff @(posedge clk_in) begin
    if (rdy_in && push && !rob_lbuffer_rst_in) begin
      addr_mem_q[tail_q] <= addrunit_lbuffer_addr_in;
      dest_mem_q[tail_q] <= addrunit_lbuffer_dest_in;
      op_mem_q[tail_q]   <= addrunit_lbuffer_opcode_in;
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q      <= IDLE;
      head_q       <= '0;
      tail_q       <= '0;
      count_q      <= '0;
      mem_en_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_size_q   <= '0;
      cdb_b_q      <= '0;
      cdb_result_q <= '0;
    end else if (rdy_in) begin
      mem_en_q <= 1'b0;
      cdb_b_q  <= '0;
      if (rob_lbuffer_rst_in) begin
        head_q  <= '0;
        tail_q  <= '0;
        count_q <= '0;
        // An outstanding read must still be absorbed unless it lands this cycle.
        state_q <= (state_q == WAIT && !mem_lbuffer_valid_in) ? DRAIN : IDLE;
      end else begin
        if (push) tail_q <= tail_q + 1'b1;
        count_q <= count_d;
        case (state_q)
          IDLE: begin
            if (count_q != '0) begin
              mem_en_q   <= 1'b1;
              mem_addr_q <= addr_mem_q[head_q];
              mem_size_q <= head_size;
              state_q    <= WAIT;
            end
          end
          WAIT: begin
            if (mem_lbuffer_valid_in) begin
              cdb_b_q      <= dest_mem_q[head_q];
              cdb_result_q <= ext_data;
              head_q       <= head_q + 1'b1;
              state_q      <= IDLE;
            end
          end
          DRAIN: begin
            if (mem_lbuffer_valid_in) state_q <= IDLE;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  a_no_overflow: assert property (@(posedge clk_in) disable iff (rst_in)
    !(rdy_in && addrunit_lbuffer_en_in && !rob_lbuffer_rst_in && full));

endmodule
